// File: rtl/status_led_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Package : status_led_pkg                                         |
// | Brief   : Mode encodings and width helper for the status LED     |
// |           controller.                                            |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package status_led_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ON      = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SLOW    = 3'd2;
    localparam logic [MODE_W-1:0] MODE_FAST    = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ACT     = 3'd4;
    localparam logic [MODE_W-1:0] MODE_BTN     = 3'd5;
    localparam logic [MODE_W-1:0] MODE_ACT_INV = 3'd6;
    localparam logic [MODE_W-1:0] MODE_RSVD    = 3'd7;

    // Bits needed to hold 0..max_val; never less than one so that
    // degenerate parameter values still give legal vectors.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_led_channel.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module  : status_led_channel                                     |
// | Brief   : One LED channel: activity stretch counter, button      |
// |           synchroniser + debouncer and the mode multiplexer.     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module status_led_channel
    import status_led_pkg::*;
#(
    parameter int STRETCH_TICKS  = 5,
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tick,
    input  logic              i_slow_phase,
    input  logic              i_fast_phase,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_enable,
    input  logic              i_event,
    input  logic              i_push_btn,
    output logic              o_led
);

    localparam int c_STR_W = cnt_width(STRETCH_TICKS);
    localparam int c_DEB_W = cnt_width(DEBOUNCE_TICKS - 1);
    localparam logic [c_STR_W-1:0] c_STR_LOAD = c_STR_W'(STRETCH_TICKS);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_TICKS - 1);

    logic [c_STR_W-1:0] r_stretch;
    logic [c_STR_W-1:0] w_stretch_next;
    logic [1:0]         r_sync;
    logic               r_deb;
    logic               w_deb_next;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic [c_DEB_W-1:0] w_deb_cnt_next;
    logic               w_mode_fn;
    logic               r_led;

    // Stretch counter: a strobe (re)loads and beats a coincident tick.
    always_comb begin
        w_stretch_next = r_stretch;
        if (i_event) begin
            w_stretch_next = c_STR_LOAD;
        end else if (i_tick && (r_stretch != '0)) begin
            w_stretch_next = r_stretch - c_STR_W'(1);
        end
    end

    // Debounce: count ticks of disagreement, any agreeing tick clears.
    always_comb begin
        w_deb_next     = r_deb;
        w_deb_cnt_next = r_deb_cnt;
        if (i_tick) begin
            if (r_sync[1] != r_deb) begin
                if (r_deb_cnt == c_DEB_LAST) begin
                    w_deb_next     = r_sync[1];
                    w_deb_cnt_next = '0;
                end else begin
                    w_deb_cnt_next = r_deb_cnt + c_DEB_W'(1);
                end
            end else begin
                w_deb_cnt_next = '0;
            end
        end
    end

    // Mode mux works on next-state values so o_led lags inputs by one cycle.
    always_comb begin
        w_mode_fn = 1'b0;
        case (i_mode)
            MODE_OFF:     w_mode_fn = 1'b0;
            MODE_ON:      w_mode_fn = 1'b1;
            MODE_SLOW:    w_mode_fn = i_slow_phase;
            MODE_FAST:    w_mode_fn = i_fast_phase;
            MODE_ACT:     w_mode_fn = (w_stretch_next != '0);
            MODE_BTN:     w_mode_fn = w_deb_next;
            MODE_ACT_INV: w_mode_fn = (w_stretch_next == '0);
            MODE_RSVD:    w_mode_fn = 1'b0;
            default:      w_mode_fn = 1'b0;
        endcase
    end

    // Channel state and registered LED drive.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stretch <= '0;
            r_sync    <= '0;
            r_deb     <= 1'b0;
            r_deb_cnt <= '0;
            r_led     <= 1'b0;
        end else begin
            r_stretch <= w_stretch_next;
            r_sync    <= {r_sync[0], i_push_btn};
            r_deb     <= w_deb_next;
            r_deb_cnt <= w_deb_cnt_next;
            r_led     <= i_enable & w_mode_fn;
        end
    end

    assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/status_led_array.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module  : status_led_array                                       |
// | Brief   : Front-panel status LED controller. Shared prescaler    |
// |           and blink phases, NUM_LEDS independent channels.       |
// |           Define LED_PWM_DIM_EN to add global PWM dimming via    |
// |           i_brightness.                                          |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module status_led_array
    import status_led_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int TICK_DIV       = 1_562_500,
    parameter int BLINK_TICKS    = 50,
    parameter int FAST_TICKS     = 10,
    parameter int STRETCH_TICKS  = 5,
    parameter int DEBOUNCE_TICKS = 2
`ifdef LED_PWM_DIM_EN
    ,
    parameter int PWM_BITS       = 4
`endif
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [MODE_W*NUM_LEDS-1:0] i_mode,
    input  logic [NUM_LEDS-1:0]        i_DIP_sw,
    input  logic [NUM_LEDS-1:0]        i_event,
    input  logic [NUM_LEDS-1:0]        i_push_btn,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_BITS-1:0]        i_brightness,
`endif
    output logic [NUM_LEDS-1:0]        o_led,
    output logic                       o_tick
);

    localparam int c_TICK_W = cnt_width(TICK_DIV - 1);
    localparam int c_SLOW_W = cnt_width(BLINK_TICKS - 1);
    localparam int c_FAST_W = cnt_width(FAST_TICKS - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_SLOW_W-1:0] c_SLOW_LAST = c_SLOW_W'(BLINK_TICKS - 1);
    localparam logic [c_FAST_W-1:0] c_FAST_LAST = c_FAST_W'(FAST_TICKS - 1);

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_TICK_W-1:0] w_tick_cnt_next;
    logic                r_tick;
    logic [c_SLOW_W-1:0] r_slow_cnt;
    logic [c_FAST_W-1:0] r_fast_cnt;
    logic                r_slow_phase;
    logic                r_fast_phase;
    logic                w_pwm_on;

    // Wrapping prescaler; the tick flag is registered alongside the count.
    always_comb begin
        w_tick_cnt_next = (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + c_TICK_W'(1);
    end

    // Prescaler and tick strobe, high while the count sits at its last value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_cnt_next;
            r_tick     <= (w_tick_cnt_next == c_TICK_LAST);
        end
    end

    // Global blink phases shared by every channel so same-mode LEDs align.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_slow_cnt   <= '0;
            r_fast_cnt   <= '0;
            r_slow_phase <= 1'b0;
            r_fast_phase <= 1'b0;
        end else if (r_tick) begin
            if (r_slow_cnt == c_SLOW_LAST) begin
                r_slow_cnt   <= '0;
                r_slow_phase <= ~r_slow_phase;
            end else begin
                r_slow_cnt <= r_slow_cnt + c_SLOW_W'(1);
            end
            if (r_fast_cnt == c_FAST_LAST) begin
                r_fast_cnt   <= '0;
                r_fast_phase <= ~r_fast_phase;
            end else begin
                r_fast_cnt <= r_fast_cnt + c_FAST_W'(1);
            end
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] r_pwm_cnt;

    // Free-running PWM counter; duty is brightness / 2^PWM_BITS.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    assign w_pwm_on = (r_pwm_cnt < i_brightness);
`else
    assign w_pwm_on = 1'b1;
`endif

    // PWM gating is folded into the channel enable so o_led stays one register deep.
    generate
        for (genvar n = 0; n < NUM_LEDS; n++) begin : g_chan
            status_led_channel #(
                .STRETCH_TICKS  (STRETCH_TICKS),
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
            ) u_chan (
                .i_clk        (i_clk),
                .i_reset      (i_reset),
                .i_tick       (r_tick),
                .i_slow_phase (r_slow_phase),
                .i_fast_phase (r_fast_phase),
                .i_mode       (i_mode[MODE_W*n +: MODE_W]),
                .i_enable     (i_DIP_sw[n] & w_pwm_on),
                .i_event      (i_event[n]),
                .i_push_btn   (i_push_btn[n]),
                .o_led        (o_led[n])
            );
        end
    endgenerate

    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_status_led_array.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module  : tb_status_led_array                                    |
// | Brief   : Directed scoreboard bench for status_led_array with    |
// |           TICK_DIV=4, BLINK=2, FAST=1, STRETCH=3, DEBOUNCE=2.    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_status_led_array;

    localparam int NUM_LEDS = 8;

    logic                  i_clk;
    logic                  i_reset;
    logic [3*NUM_LEDS-1:0] i_mode;
    logic [NUM_LEDS-1:0]   i_DIP_sw;
    logic [NUM_LEDS-1:0]   i_event;
    logic [NUM_LEDS-1:0]   i_push_btn;
    logic [NUM_LEDS-1:0]   o_led;
    logic                  o_tick;
`ifdef LED_PWM_DIM_EN
    logic [3:0]            i_brightness;
`endif

    status_led_array #(
        .NUM_LEDS       (NUM_LEDS),
        .TICK_DIV       (4),
        .BLINK_TICKS    (2),
        .FAST_TICKS     (1),
        .STRETCH_TICKS  (3),
        .DEBOUNCE_TICKS (2)
`ifdef LED_PWM_DIM_EN
        ,
        .PWM_BITS       (4)
`endif
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_mode       (i_mode),
        .i_DIP_sw     (i_DIP_sw),
        .i_event      (i_event),
        .i_push_btn   (i_push_btn),
`ifdef LED_PWM_DIM_EN
        .i_brightness (i_brightness),
`endif
        .o_led        (o_led),
        .o_tick       (o_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] exp;
        bit         tchk;
        logic       texp;
        string      name;
    } item_t;

    item_t q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    k      = 0;   // rising edges since the last reset release

    // LED gating expected from the PWM counter (free-running from reset).
    function automatic bit pwm_gate(input int kk);
`ifdef LED_PWM_DIM_EN
        return (((kk - 1) % 16) < int'(i_brightness));
`else
        return (kk >= 0);
`endif
    endfunction

    task automatic chk(input logic [7:0] mask, input logic [7:0] val,
                       input bit tchk, input logic tval, input string name);
        item_t it;
        it.mask = mask;
        it.exp  = val & mask & (pwm_gate(k) ? 8'hFF : 8'h00);
        it.tchk = tchk;
        it.texp = tval;
        it.name = name;
        q.push_back(it);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        k++;
    endtask

    // Monitor: every falling edge, compare the outputs against queued expectations.
    initial begin
        item_t it;
        forever begin
            @(negedge i_clk);
            while (q.size() > 0) begin
                it = q.pop_front();
                if (it.mask != 8'h00) begin
                    n_chk++;
                    if ((o_led & it.mask) === it.exp) n_pass++;
                    else $display("FAIL %s: o_led&mask=%b required %b", it.name, o_led & it.mask, it.exp);
                end
                if (it.tchk) begin
                    n_chk++;
                    if (o_tick === it.texp) n_pass++;
                    else $display("FAIL %s: o_tick=%b required %b", it.name, o_tick, it.texp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        i_reset    = 1'b1;
        // ch7 OFF, ch6 RSVD, ch5 ON, ch4 ACT_INV, ch3 BTN, ch2 ACT, ch1 FAST, ch0 SLOW
        i_mode     = {3'd0, 3'd7, 3'd1, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
        i_DIP_sw   = 8'hFF;
        i_event    = 8'h00;
        i_push_btn = 8'h00;
`ifdef LED_PWM_DIM_EN
        i_brightness = 4'd15;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        k = 0;
        chk(8'hFF, 8'h00, 1, 1'b0, "reset state");

        // Blink, tick and DIP checks.
        repeat (19) begin
            step();
            case (k)
                1:  chk(8'h00, 8'h00, 1, 1'b0, "tick edge1");
                2:  chk(8'h00, 8'h00, 1, 1'b0, "tick edge2");
                3:  chk(8'h00, 8'h00, 1, 1'b1, "first tick");
                4:  chk(8'h03, 8'h00, 1, 1'b0, "blink start");
                5:  chk(8'hFF, 8'h32, 0, 1'b0, "all channels");
                8:  chk(8'h03, 8'h02, 0, 1'b0, "fast high");
                9:  chk(8'h03, 8'h01, 0, 1'b0, "slow high fast low");
                10: begin chk(8'h01, 8'h01, 0, 1'b0, "slow before dip"); i_DIP_sw = 8'hFE; end
                11: begin chk(8'h01, 8'h00, 0, 1'b0, "dip off"); i_DIP_sw = 8'hFF; end
                12: chk(8'h03, 8'h01, 0, 1'b0, "dip restored");
                13: chk(8'h03, 8'h03, 0, 1'b0, "both high");
                17: chk(8'h03, 8'h00, 0, 1'b0, "both low");
                default: ;
            endcase
        end

        // Asynchronous reset mid-run, while o_tick and o_led are high.
        i_reset = 1'b1;
        chk(8'hFF, 8'h00, 1, 1'b0, "async reset");
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        k = 0;

        // Activity, inverted activity, reserved mode and button.
        repeat (76) begin
            step();
            case (k)
                1:  begin chk(8'h54, 8'h10, 0, 1'b0, "act idle"); i_event = 8'h54; i_push_btn = 8'h40; end
                2:  begin i_event = 8'h00; chk(8'h54, 8'h04, 1, 1'b0, "act on"); end
                3:  chk(8'h00, 8'h00, 1, 1'b1, "first tick after reset");
                11: chk(8'h54, 8'h04, 0, 1'b0, "act held");
                12: chk(8'h54, 8'h10, 0, 1'b0, "act expire");
                13: i_event = 8'h54;
                14: begin i_event = 8'h00; chk(8'h54, 8'h04, 0, 1'b0, "act reload"); end
                20: chk(8'h54, 8'h04, 0, 1'b0, "act before retrigger");
                21: i_event = 8'h54;
                22: begin i_event = 8'h00; chk(8'h54, 8'h04, 0, 1'b0, "retrigger load"); end
                24: chk(8'h54, 8'h04, 0, 1'b0, "retrigger extends");
                31: chk(8'h54, 8'h04, 0, 1'b0, "retrigger last");
                32: chk(8'h54, 8'h10, 0, 1'b0, "retrigger expire");
                35: begin chk(8'h00, 8'h00, 1, 1'b1, "tick at strobe"); i_event = 8'h54; end
                36: begin i_event = 8'h00; chk(8'h54, 8'h04, 0, 1'b0, "coincident load"); end
                44: chk(8'h54, 8'h04, 0, 1'b0, "coincident no decrement");
                47: chk(8'h54, 8'h04, 0, 1'b0, "coincident last");
                48: chk(8'h54, 8'h10, 0, 1'b0, "coincident expire");
                49: i_push_btn = 8'h48;
                53: i_push_btn = 8'h40;
                56: chk(8'h48, 8'h00, 0, 1'b0, "btn short pulse");
                57: begin chk(8'h48, 8'h00, 0, 1'b0, "btn short ignored"); i_push_btn = 8'h48; end
                63: chk(8'h48, 8'h00, 0, 1'b0, "btn press pending");
                64: chk(8'h48, 8'h08, 0, 1'b0, "btn pressed");
                69: i_push_btn = 8'h40;
                75: chk(8'h48, 8'h08, 0, 1'b0, "btn release pending");
                76: chk(8'h48, 8'h00, 0, 1'b0, "btn released");
                default: ;
            endcase
        end

`ifdef LED_PWM_DIM_EN
        // ch5 is ON: follows pwm_cnt < brightness, then never lights at zero.
        step();
        i_brightness = 4'd8;
        repeat (16) begin
            step();
            chk(8'h20, 8'h20, 0, 1'b0, "pwm half duty");
        end
        i_brightness = 4'd0;
        repeat (16) begin
            step();
            chk(8'h20, 8'h20, 0, 1'b0, "pwm zero");
        end
`endif

        repeat (2) @(negedge i_clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d items left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
